// File: rtl/alarm_ring_if.sv
// Signal bundle between the time-compare/UI side (master) and the alarm ring controller (slave).
interface alarm_ring_if;
  logic       alarm_en;
  logic [5:0] clockhour;
  logic [5:0] clockminute;
  logic [5:0] alarmhour;
  logic [5:0] alarmminute;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_cnt;

  modport master (
    output alarm_en, clockhour, clockminute, alarmhour, alarmminute, snooze_btn, stop_btn,
    input  buzzer, ringing, snoozing, snooze_cnt
  );

  modport slave (
    input  alarm_en, clockhour, clockminute, alarmhour, alarmminute, snooze_btn, stop_btn,
    output buzzer, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer on the 1 Hz tick: ring, snooze, timeout, dismiss, with no re-trigger in the
// matched minute. Define ALARM_BEEP_EN for a toggling buzzer; otherwise the tone is steady.
module alarm_ring_controller #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned CNT_W      = 9
) (
  input  logic         clk_1hz,
  input  logic         rst,
  alarm_ring_if.slave  bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRinging = 2'd1;
  localparam logic [1:0] StSnooze  = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  localparam logic [CNT_W-1:0] RingLast   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SnoozeLast = CNT_W'(SNOOZE_SEC - 1);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [2:0]       SnoozeMax  = 3'(MAX_SNOOZE);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [2:0]       snooze_cnt_q, snooze_cnt_d;
  logic             buzzer_q, buzzer_d;
  logic             ringing_q, ringing_d;
  logic             snoozing_q, snoozing_d;
  logic             match;
  logic [CNT_W-1:0] sec_cnt_inc;

  assign match = (bus.clockhour == bus.alarmhour) && (bus.clockminute == bus.alarmminute);
  assign sec_cnt_inc = (sec_cnt_q == CntMax) ? sec_cnt_q : sec_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!bus.alarm_en) begin
      state_d      = StIdle;
      sec_cnt_d    = '0;
      snooze_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (match) begin
            state_d   = StRinging;
            sec_cnt_d = '0;
          end
        end
        StRinging: begin
          if (bus.stop_btn) begin
            state_d = StDone;
          end else if (bus.snooze_btn && (snooze_cnt_q < SnoozeMax)) begin
            state_d      = StSnooze;
            sec_cnt_d    = '0;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
          end else if (sec_cnt_q == RingLast) begin
            state_d = StDone;
          end else begin
            sec_cnt_d = sec_cnt_inc;
          end
        end
        StSnooze: begin
          // Snooze runs on the counter alone; the clock may have left the alarm minute.
          if (bus.stop_btn) begin
            state_d = StDone;
          end else if (sec_cnt_q == SnoozeLast) begin
            state_d   = StRinging;
            sec_cnt_d = '0;
          end else begin
            sec_cnt_d = sec_cnt_inc;
          end
        end
        StDone: begin
          if (!match) begin
            state_d      = StIdle;
            snooze_cnt_d = '0;
          end
        end
        default: begin
          state_d      = StIdle;
          sec_cnt_d    = '0;
          snooze_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ringing_d  = (state_d == StRinging);
    snoozing_d = (state_d == StSnooze);
`ifdef ALARM_BEEP_EN
    // Start high on every entry into ringing, then alternate each tick.
    if (state_d == StRinging) begin
      buzzer_d = (state_q == StRinging) ? ~buzzer_q : 1'b1;
    end else begin
      buzzer_d = 1'b0;
    end
`else
    buzzer_d = (state_d == StRinging);
`endif
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sec_cnt_q    <= '0;
      snooze_cnt_q <= '0;
      buzzer_q     <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      buzzer_q     <= buzzer_d;
      ringing_q    <= ringing_d;
      snoozing_q   <= snoozing_d;
    end
  end

  assign bus.buzzer     = buzzer_q;
  assign bus.ringing    = ringing_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller: expectations are queued per tick and checked after
// each rising edge; buzzer expectations follow ALARM_BEEP_EN when it is defined.
module tb_alarm_ring_controller;

  logic clk_1hz = 1'b0;
  logic rst     = 1'b1;

  alarm_ring_if bus ();

  alarm_ring_controller dut (
    .clk_1hz (clk_1hz),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk_1hz = ~clk_1hz;

  // exp packs {ringing, snoozing, buzzer, snooze_cnt[2:0]}
  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_ring = 1'b0;
  logic prev_buz  = 1'b0;

  task automatic push(input string tag, input logic r, input logic s, input logic [2:0] c);
    exp_t e;
    logic b;
`ifdef ALARM_BEEP_EN
    b = r ? (prev_ring ? ~prev_buz : 1'b1) : 1'b0;
`else
    b = r;
`endif
    prev_ring = r;
    prev_buz  = b;
    e.tag = tag;
    e.exp = {r, s, b, c};
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t       e;
    logic [5:0] obs;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {bus.ringing, bus.snoozing, bus.buzzer, bus.snooze_cnt};
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic [2:0] c);
    push(tag, r, s, c);
    @(posedge clk_1hz);
    #1;
    check_pop();
  endtask

  initial begin
    bus.alarm_en    = 1'b1;
    bus.clockhour   = 6'd7;
    bus.clockminute = 6'd29;
    bus.alarmhour   = 6'd7;
    bus.alarmminute = 6'd30;
    bus.snooze_btn  = 1'b0;
    bus.stop_btn    = 1'b0;

    #2;
    push("reset_state", 1'b0, 1'b0, 3'd0);
    check_pop();
    #1 rst = 1'b0;
    @(posedge clk_1hz);
    #1;

    // Plain ring to timeout, hold in DONE, release on minute change
    step("idle_nomatch", 1'b0, 1'b0, 3'd0);
    bus.clockminute = 6'd30;
    step("ring_start", 1'b1, 1'b0, 3'd0);
    repeat (59) step("ringing", 1'b1, 1'b0, 3'd0);
    step("ring_timeout", 1'b0, 1'b0, 3'd0);
    repeat (3) step("done_no_rering", 1'b0, 1'b0, 3'd0);
    bus.clockminute = 6'd31;
    step("done_to_idle", 1'b0, 1'b0, 3'd0);

    // Snooze once, leave the minute during snooze, snooze_btn inert while snoozing
    bus.clockminute = 6'd30;
    step("ring_start2", 1'b1, 1'b0, 3'd0);
    bus.snooze_btn = 1'b1;
    step("snooze1", 1'b0, 1'b1, 3'd1);
    bus.snooze_btn  = 1'b0;
    bus.clockminute = 6'd35;
    repeat (100) step("snoozing1", 1'b0, 1'b1, 3'd1);
    bus.snooze_btn = 1'b1;
    step("snooze_btn_inert", 1'b0, 1'b1, 3'd1);
    bus.snooze_btn = 1'b0;
    repeat (198) step("snoozing1", 1'b0, 1'b1, 3'd1);
    step("resnooze_ring1", 1'b1, 1'b0, 3'd1);
    step("ring_after_snz1", 1'b1, 1'b0, 3'd1);

    // Exhaust snoozes; the extra request is ignored
    bus.snooze_btn = 1'b1;
    step("snooze2", 1'b0, 1'b1, 3'd2);
    bus.snooze_btn = 1'b0;
    repeat (299) step("snoozing2", 1'b0, 1'b1, 3'd2);
    step("resnooze_ring2", 1'b1, 1'b0, 3'd2);
    bus.snooze_btn = 1'b1;
    step("snooze3", 1'b0, 1'b1, 3'd3);
    bus.snooze_btn = 1'b0;
    repeat (299) step("snoozing3", 1'b0, 1'b1, 3'd3);
    step("resnooze_ring3", 1'b1, 1'b0, 3'd3);
    bus.snooze_btn = 1'b1;
    repeat (3) step("snooze4_ignored", 1'b1, 1'b0, 3'd3);
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b1;
    step("stop_to_done", 1'b0, 1'b0, 3'd3);
    bus.stop_btn = 1'b0;
    step("done_idle_clr", 1'b0, 1'b0, 3'd0);

    // Stop and snooze together: stop wins, count untouched, no re-ring in the minute
    bus.clockminute = 6'd30;
    step("ring_start3", 1'b1, 1'b0, 3'd0);
    bus.stop_btn   = 1'b1;
    bus.snooze_btn = 1'b1;
    step("stop_beats_snooze", 1'b0, 1'b0, 3'd0);
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
    repeat (3) step("same_min_no_rering", 1'b0, 1'b0, 3'd0);
    bus.clockminute = 6'd31;
    step("idle_again", 1'b0, 1'b0, 3'd0);

    // Asynchronous reset between edges while ringing
    bus.clockminute = 6'd30;
    step("ring_start4", 1'b1, 1'b0, 3'd0);
    step("ringing4", 1'b1, 1'b0, 3'd0);
    #3 rst = 1'b1;
    #1;
    push("async_rst", 1'b0, 1'b0, 3'd0);
    check_pop();
    #1 rst = 1'b0;
    step("ring_after_rst", 1'b1, 1'b0, 3'd0);

    // alarm_en drop during snooze
    bus.snooze_btn = 1'b1;
    step("snooze_en_test", 1'b0, 1'b1, 3'd1);
    bus.snooze_btn = 1'b0;
    step("snoozing_en_test", 1'b0, 1'b1, 3'd1);
    bus.alarm_en = 1'b0;
    step("en_off_idle", 1'b0, 1'b0, 3'd0);
    step("en_off_hold", 1'b0, 1'b0, 3'd0);
    bus.alarm_en = 1'b1;
    step("en_on_ring", 1'b1, 1'b0, 3'd0);

    // Alarm time edited while ringing: keeps ringing, then DONE releases to IDLE
    bus.alarmminute = 6'd40;
    repeat (2) step("alarm_edit_ring", 1'b1, 1'b0, 3'd0);
    bus.stop_btn = 1'b1;
    step("edit_stop", 1'b0, 1'b0, 3'd0);
    bus.stop_btn = 1'b0;
    repeat (2) step("edit_idle", 1'b0, 1'b0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
